// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM encoding and a
// constant clog2 used to size index ports.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority search: first set bit of req scanning
// start, start+1, ... modulo N.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   start,
  output logic                  found,
  output logic [clog2(N)-1:0]   idx
);

  localparam int IW = clog2(N);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to its
// SLICE field + 1 cycles while others wait; all outputs are registered.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          REQ,
  input  logic [N*CNT_W-1:0]    SLICE,
  output logic [N-1:0]          GNT,
  output logic [clog2(N)-1:0]   GNT_ID,
  output logic                  GNT_VLD
);

  localparam int IW = clog2(N);

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    owner_n, owner_inc, start, idx;
  logic [CNT_W-1:0] cnt, cnt_n, limit, limit_n;
  logic [CNT_W-1:0] slice_idx;
  logic [N-1:0]     gnt_n;
  logic             found;

  // GNT_ID doubles as the owner register; while granted, search begins past it.
  assign owner_inc = (GNT_ID == IW'(N - 1)) ? '0 : GNT_ID + IW'(1);
  assign start     = (state == GRANT) ? owner_inc : ptr;
  assign slice_idx = SLICE[int'(idx)*CNT_W +: CNT_W];

  rr_priority_pick #(.N(N)) u_pick (
    .req   (REQ),
    .start (start),
    .found (found),
    .idx   (idx)
  );

  always_comb begin
    state_n = state;
    owner_n = GNT_ID;
    ptr_n   = ptr;
    cnt_n   = cnt;
    limit_n = limit;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = idx;
          cnt_n   = '0;
          limit_n = slice_idx;
        end
      end
      GRANT: begin
        if (REQ[GNT_ID]) begin
          if (cnt < limit) begin
            cnt_n = cnt + CNT_W'(1);
          end else begin
            // Owner still requests, so the scan always finds someone (itself at worst).
            owner_n = idx;
            cnt_n   = '0;
            limit_n = slice_idx;
            if (idx != GNT_ID) ptr_n = owner_inc;
          end
        end else begin
          ptr_n = owner_inc;
          cnt_n = '0;
          if (found) begin
            owner_n = idx;
            limit_n = slice_idx;
          end else begin
            state_n = IDLE;
            owner_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    gnt_n = '0;
    if (state_n == GRANT) gnt_n[owner_n] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      limit   <= '0;
      GNT     <= '0;
      GNT_ID  <= '0;
      GNT_VLD <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      limit   <= limit_n;
      GNT     <= gnt_n;
      GNT_ID  <= owner_n;
      GNT_VLD <= (state_n == GRANT);
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter (N=4, CNT_W=4): directed scenarios plus
// randomized traffic against a tenure-based reference model.
module tb_weighted_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] slice;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_vld;

  int checks   = 0;
  int failures = 0;

  // Reference model: current owner (-1 when idle), rotation pointer,
  // cycles granted so far in this tenure and the tenure's allowed length.
  int m_owner;
  int m_ptr;
  int m_used;
  int m_len;

  weighted_rr_arbiter #(.N(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .REQ     (req),
    .SLICE   (slice),
    .GNT     (gnt),
    .GNT_ID  (gnt_id),
    .GNT_VLD (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_req(input logic [3:0] r, input int from, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_used  = 0;
    m_len   = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [15:0] s);
    int nj;
    if (m_owner < 0) begin
      nj = first_req(r, m_ptr, 4);
      if (nj >= 0) begin
        m_owner = nj;
        m_used  = 1;
        m_len   = int'(s[nj*4 +: 4]) + 1;
      end
    end else if (r[m_owner]) begin
      if (m_used < m_len) begin
        m_used++;
      end else begin
        nj = first_req(r, (m_owner + 1) % 4, 3);
        if (nj >= 0) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = nj;
        end
        m_used = 1;
        m_len  = int'(s[m_owner*4 +: 4]) + 1;
      end
    end else begin
      m_ptr = (m_owner + 1) % 4;
      nj    = first_req(r, m_ptr, 4);
      if (nj >= 0) begin
        m_owner = nj;
        m_used  = 1;
        m_len   = int'(s[nj*4 +: 4]) + 1;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  // One clock: inputs already driven; model follows the sampled values.
  task automatic step(input string tag);
    logic [3:0]  rs;
    logic [15:0] ss;
    logic [3:0]  exp_gnt;
    rs = req;
    ss = slice;
    @(posedge clk);
    model_edge(rs, ss);
    #1;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check_eq({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, ":gnt_id"}, 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_eq({tag, ":gnt_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
    check_eq({tag, ":onehot"}, 32'($onehot0(gnt)), 32'd1);
    check_eq({tag, ":vld_or"}, 32'(gnt_vld), 32'(|gnt));
    check_eq({tag, ":id_match"}, 32'(gnt_id), 32'(idx_of(gnt)));
    check_eq({tag, ":req_held"}, 32'((gnt == 4'b0) || ((gnt & rs) != 4'b0)), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int run;
    rst_n = 1'b1;
    req   = '0;
    slice = '0;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    check_eq("reset:gnt", 32'(gnt), 32'd0);
    check_eq("reset:gnt_id", 32'(gnt_id), 32'd0);
    check_eq("reset:gnt_vld", 32'(gnt_vld), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester keeps the grant through fresh slices.
    req = 4'b0100;
    slice = 16'h0000;
    for (int i = 0; i < 6; i++) step("single");
    check_eq("single:final_gnt", 32'(gnt), 32'h4);

    // Full contention, one cycle each.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) step("contend");

    // Weighted: field0=2 gives 3 cycles, field1=0 gives 1.
    do_reset();
    req = 4'b0011;
    slice = 16'h0002;
    for (int i = 0; i < 12; i++) step("weighted");

    // All-ones slice: 16 consecutive cycles under contention.
    do_reset();
    req = 4'b0011;
    slice = 16'h000F;
    for (int i = 0; i < 20; i++) step("slice_max");

    // Early release: owner 1 drops its request on its second cycle.
    do_reset();
    slice = 16'h0050;
    req = 4'b0010;
    step("early1");
    req = 4'b1010;
    step("early2");
    req = 4'b1000;
    step("early3");
    check_eq("early:gnt", 32'(gnt), 32'h8);
    check_eq("early:ptr", 32'(dut.ptr), 32'd2);

    // Slice change during a tenure does not alter its length.
    do_reset();
    req = 4'b0011;
    slice = 16'h0003;
    step("midchg");
    slice = 16'h0000;
    run = (gnt == 4'b0001) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step("midchg");
      if (gnt == 4'b0001) run++;
      else break;
    end
    check_eq("midchg:tenure_len", 32'(run), 32'd4);

    // Asynchronous reset in the middle of a grant.
    step("pre_rst");
    check_eq("pre_rst:vld", 32'(gnt_vld), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst:gnt", 32'(gnt), 32'd0);
    check_eq("async_rst:gnt_vld", 32'(gnt_vld), 32'd0);
    check_eq("async_rst:gnt_id", 32'(gnt_id), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req = 4'b1010;
    step("post_rst");
    check_eq("post_rst:first", 32'(gnt), 32'h2);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      for (int f = 0; f < 4; f++) begin
        slice[f*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      end
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 4: width of each per-requester slice field and the internal slice counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port REQ, input, N: request bits, one per requester, level-sensitive.
REQ-006 SHALL have port SLICE, input, N*CNT_W: field i is SLICE[i*CNT_W +: CNT_W], and requester i's slice is field i + 1 cycles.
REQ-007 SHALL have port GNT, output reg, N: one-hot or all-zero grant.
REQ-008 SHALL have port GNT_ID, output reg, clog2(N): index of the current owner, 0 when GNT is all-zero.
REQ-009 SHALL have port GNT_VLD, output reg, 1: high exactly when GNT is non-zero.

Function
REQ-010 SHALL use two states: IDLE (no owner) and GRANT (owner registered).
REQ-011 SHALL hold a pointer register; pick = first i with REQ[i]=1 scanning pointer, pointer+1, ... modulo N.
REQ-012 In IDLE, any REQ bit set at an edge SHALL move to GRANT with owner = pick, and GNT/GNT_ID/GNT_VLD SHALL reflect it after that same edge (latency 1 cycle).
REQ-013 On entering GRANT, the owner's SLICE field SHALL be latched into a limit register and the counter cleared; later SLICE changes SHALL not affect the current tenure.
REQ-014 In GRANT with REQ[owner]=1 and counter < limit, the counter SHALL increment and the owner SHALL be kept.
REQ-015 In GRANT with REQ[owner]=1 and counter == limit, the block SHALL re-arbitrate starting at owner+1 (mod N). If another requester is found, ownership SHALL pass to it; otherwise the same owner SHALL be kept with a fresh slice (counter cleared, limit re-latched).
REQ-016 In GRANT with REQ[owner]=0, the block SHALL re-arbitrate starting at owner+1 in the same cycle. The next owner, or IDLE if no request, SHALL take effect after that edge, with no dead cycle.
REQ-017 The pointer SHALL become owner+1 (mod N) whenever an owner loses the grant, and SHALL be unchanged otherwise.
REQ-018 GNT SHALL never have more than one bit set; switching between owners SHALL be direct, with no all-zero cycle between them.
REQ-019 An owner SHALL receive at most SLICE field+1 consecutive grant cycles while any other requester is asserted; field=0 gives 1 cycle and all-ones gives 2^CNT_W cycles.
REQ-020 The counter SHALL never wrap; counter == limit SHALL be the only slice-expiry condition.
REQ-021 Requests that rise and fall between edges SHALL be ignored; only sampled values count.
REQ-022 All outputs SHALL be registered directly, with no combinational path from REQ to GNT.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, pointer=0, counter=0, limit=0, GNT=0, GNT_ID=0, GNT_VLD=0.
REQ-024 Reset asserted mid-tenure SHALL drop the grant immediately, with no completion of the slice.
REQ-025 After reset release, the first arbitration SHALL start from requester 0.

Structure
REQ-026 A shared package arb_pkg SHALL hold the state encoding (IDLE, GRANT) and a clog2 constant function.
REQ-027 The rotating priority pick SHALL be a combinational sub-module rr_priority_pick with parameter N and ports req, start, found, idx. It SHALL be instanced once, with the start input muxed between pointer and owner+1.
REQ-028 The top level SHALL contain only the FSM, counter, limit, pointer and output registers.

Verification (N=4, CNT_W=4)
REQ-029 Single request: REQ=0100 held, SLICE all 0 -> GNT=0100, GNT_ID=2 one cycle later, held continuously with no gaps (fresh slices).
REQ-030 Full contention: REQ=1111 held, SLICE all 0 -> GNT cycles 0001,0010,0100,1000,0001..., one cycle each.
REQ-031 Weighted slices: REQ=0011, field0=2, field1=0 -> pattern 3x GNT=0001 then 1x GNT=0010, repeating.
REQ-032 Early release: owner 1 with field1=5 drops REQ[1] on its 2nd cycle while REQ[3]=1 -> GNT=1000 on the next edge, no all-zero cycle, pointer=2.
REQ-033 Mid-tenure change and reset: SLICE changed during a tenure -> tenure length unchanged. rst_n pulsed low mid-grant -> GNT=0 asynchronously, and after release REQ=1010 -> GNT=0010 first.
REQ-034 Every run SHALL continuously check: GNT one-hot or zero, GNT_VLD == |GNT, GNT_ID consistent with GNT, grant only to a requester whose REQ was 1 at the preceding edge.
